// File: rtl/mqoi_pkg.sv
// Shared definitions for the MQOI frame sequencer.
//   - FSM state encoding
//   - pixel width and RGBA channel offsets
//   - ALPHA_OPAQUE / DIFF_SKIP constants
package mqoi_pkg;

  localparam int PIX_W = 32;
  localparam int R_OFS = 24;
  localparam int G_OFS = 16;
  localparam int B_OFS = 8;
  localparam int A_OFS = 0;

  localparam logic [7:0]       ALPHA_OPAQUE = 8'hFF;
  localparam logic [PIX_W-1:0] DIFF_SKIP    = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_PIX  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/mqoi_pixel_diff.sv
// Combinational pixel compare/format.
//   cur       : current-frame pixel (RGBA)
//   old       : previous-frame pixel from frame memory
//   key       : force full-pixel output
//   diff      : DIFF_SKIP when RGB unchanged and not key, else {RGB, ALPHA_OPAQUE}
//   alpha_bad : current pixel alpha is not opaque
module mqoi_pixel_diff
  import mqoi_pkg::*;
(
  input  logic [PIX_W-1:0] cur,
  input  logic [PIX_W-1:0] old,
  input  logic             key,
  output logic [PIX_W-1:0] diff,
  output logic             alpha_bad
);

  logic same_rgb;

  // Alpha is deliberately left out of the compare: the encoder only sees RGB.
  assign same_rgb  = (cur[PIX_W-1:B_OFS] == old[PIX_W-1:B_OFS]);
  assign diff      = (!key && same_rgb) ? DIFF_SKIP
                                        : {cur[R_OFS +: 8], cur[G_OFS +: 8],
                                           cur[B_OFS +: 8], ALPHA_OPAQUE};
  assign alpha_bad = (cur[A_OFS +: 8] != ALPHA_OPAQUE);

endmodule

// File: rtl/mqoi_frame_sequencer.sv
// Frame sequencer: for each pixel, reads the old pixel from frame memory,
// accepts the new pixel, writes it back, and emits a diffed pixel to the
// QOI encoder. One pixel per 4 cycles at best (READ, WAIT, PIX, OUT).
//   clk, rst                      : clock, async active-high reset
//   start/keyframe/abort/num_pixels : frame control
//   in_valid/in_ready/in_rgba     : current-frame pixel stream
//   mem_rd/mem_raddr/mem_rdata    : old-frame read (data 1 cycle after mem_rd)
//   mem_we/mem_waddr/mem_wdata    : old-frame write-back
//   diff_valid/ready/rgba/last    : stream to encoder
//   busy, done (pulse), alpha_err (sticky)
module mqoi_frame_sequencer
  import mqoi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keyframe,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_pixels,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_rgba,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              diff_valid,
  input  logic              diff_ready,
  output logic [PIX_W-1:0]  diff_rgba,
  output logic              diff_last,
  output logic              busy,
  output logic              done,
  output logic              alpha_err
);

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  last_idx;
  logic               eff_key;
  logic               frame_valid;
  logic [PIX_W-1:0]   old_px;
  logic [PIX_W-1:0]   diff_q;
  logic [PIX_W-1:0]   diff_w;
  logic               alpha_bad;
  logic               is_last;

  mqoi_pixel_diff u_diff (
    .cur       (in_rgba),
    .old       (old_px),
    .key       (eff_key),
    .diff      (diff_w),
    .alpha_bad (alpha_bad)
  );

  assign is_last = (idx == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      last_idx    <= '0;
      eff_key     <= 1'b0;
      frame_valid <= 1'b0;
      old_px      <= '0;
      diff_q      <= '0;
      done        <= 1'b0;
      alpha_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Memory may be partially overwritten, so the next frame must be a key.
        state       <= S_IDLE;
        frame_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            alpha_err <= 1'b0;
            if (num_pixels != '0) begin
              last_idx <= num_pixels - 1'b1;
              eff_key  <= keyframe | ~frame_valid;
              idx      <= '0;
              state    <= S_READ;
            end else begin
              done <= 1'b1;
            end
          end
          S_READ: state <= S_WAIT;
          S_WAIT: begin
            old_px <= mem_rdata;
            state  <= S_PIX;
          end
          S_PIX: if (in_valid) begin
            diff_q <= diff_w;
            if (alpha_bad) alpha_err <= 1'b1;
            state <= S_OUT;
          end
          S_OUT: if (diff_ready) begin
            if (is_last) begin
              state       <= S_IDLE;
              done        <= 1'b1;
              frame_valid <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_READ;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs decode the registered state; address/data are zeroed when idle.
  assign busy       = (state != S_IDLE);
  assign in_ready   = (state == S_PIX);
  assign mem_rd     = (state == S_READ);
  assign mem_raddr  = mem_rd ? idx : '0;
  assign mem_we     = (state == S_PIX) && in_valid && !abort;
  assign mem_waddr  = mem_we ? idx : '0;
  assign mem_wdata  = mem_we ? in_rgba : '0;
  assign diff_valid = (state == S_OUT);
  assign diff_rgba  = diff_valid ? diff_q : '0;
  assign diff_last  = diff_valid && is_last;

endmodule
